// File: rtl/issue_scheduler_pkg.sv
// Issue scheduler shared types: per-instruction control word and the scheduled entry payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package issue_scheduler_pkg;

    localparam int REG_VAL_WIDTH          = 32;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;
    localparam int IMM_WIDTH              = 32;

    // Every 3-bit encoding is named so arbitrary payload bits stay legal.
    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_BR  = 3'd3,
        FU_LD  = 3'd4,
        FU_ST  = 3'd5,
        FU_CSR = 3'd6,
        FU_NOP = 3'd7
    } fu_op_e;

    typedef struct packed {
        fu_op_e op;
        logic   use_imm;
        logic   wr_en;
        logic   is_signed;
    } control_t;

    typedef struct packed {
        control_t                          control;
        logic [REG_VAL_WIDTH-1:0]          src1_val;
        logic [REG_VAL_WIDTH-1:0]          src2_val;
        logic [REG_VAL_WIDTH-1:0]          dst_val;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] src1_addr;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] src2_addr;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_addr;
        logic [IMM_WIDTH-1:0]              imm;
    } sched_entry_t;

endpackage

// File: rtl/issue_scheduler_if.sv
// Issue scheduler bus: RS request/accept side plus the single FU issue slot.
// Latency: n/a (wiring only).
// Backpressure: rs_ready per requester; fu_ready stalls the issue slot.
// Ports: rs_valid/rs_entry/rs_ready (RS side), fu_valid/fu_entry/fu_ready (FU side).
// Modports: master = RS array + FU (drives requests, fu_ready); slave = scheduler.
interface issue_scheduler_if #(
    parameter int NUM_RS = 4
);
    import issue_scheduler_pkg::*;

    logic [NUM_RS-1:0]         rs_valid;
    sched_entry_t [NUM_RS-1:0] rs_entry;
    logic [NUM_RS-1:0]         rs_ready;
    logic                      fu_valid;
    logic                      fu_ready;
    sched_entry_t              fu_entry;

    modport master (
        output rs_valid, rs_entry, fu_ready,
        input  rs_ready, fu_valid, fu_entry
    );

    modport slave (
        input  rs_valid, rs_entry, fu_ready,
        output rs_ready, fu_valid, fu_entry
    );

endinterface

// File: rtl/issue_scheduler_rr_arbiter.sv
// Round-robin priority picker: first asserted req at or above ptr, wrapping NUM_RS-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is present.
// Ports: req (requests), ptr (search start), grant (one-hot), winner (index of grant).
module rr_arbiter #(
    parameter int NUM_RS = 4,
    parameter int PTR_W  = $clog2(NUM_RS)
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_RS-1:0] grant,
    output logic [PTR_W-1:0]  winner
);
    logic           found;
    logic [PTR_W:0] cand;

    // One extra bit on cand lets ptr+i exceed NUM_RS-1 before the wrap subtract,
    // which keeps this correct for non-power-of-two NUM_RS.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_RS)) begin
                cand = cand - (PTR_W+1)'(NUM_RS);
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
        grant[winner] = found;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: round-robin pick of one ready RS entry into a single registered FU slot.
// Latency: 1 cycle from rs_ready grant to fu_valid/fu_entry.
// Backpressure: fu_ready=0 holds the slot and withholds all rs_ready; drain+load sustains 1/cycle.
// Ports: clk, reset (sync, active-high), flush (drops held slot), bus (issue_scheduler_if.slave).
// Optional: define ISSUE_SCHED_PERF_CNT_EN to add perf_issue_cnt / perf_stall_cnt (saturating).
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_RS = 4,
    parameter int PTR_W  = $clog2(NUM_RS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    issue_scheduler_if.slave bus
`ifdef ISSUE_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W-1:0]  winner;
    logic [NUM_RS-1:0] grant;
    logic              fu_valid_q;
    sched_entry_t      fu_entry_q;
    logic              slot_free;
    logic              load;

    rr_arbiter #(
        .NUM_RS (NUM_RS),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req    (bus.rs_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    // The slot can take a new entry when empty or when it is draining this cycle.
    // Reset is folded in so no RS sees an accept it would lose to reset.
    assign slot_free = !fu_valid_q || bus.fu_ready;
    assign load      = !reset && !flush && (|bus.rs_valid) && slot_free;
    assign next_ptr  = (winner == PTR_W'(NUM_RS - 1)) ? '0 : winner + 1'b1;

    assign bus.rs_ready = load ? grant : '0;
    assign bus.fu_valid = fu_valid_q;
    assign bus.fu_entry = fu_entry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fu_valid_q <= 1'b0;
            fu_entry_q <= '0;
            rr_ptr     <= '0;
        end else if (load) begin
            fu_valid_q <= 1'b1;
            fu_entry_q <= bus.rs_entry[winner];
            rr_ptr     <= next_ptr;
        end else if (flush || bus.fu_ready) begin
            // Entry payload is left as-is; fu_valid alone qualifies it.
            fu_valid_q <= 1'b0;
        end
    end

`ifdef ISSUE_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fu_valid_q && bus.fu_ready && (perf_issue_cnt != '1)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (fu_valid_q && !bus.fu_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
